jesd204_tx_link_bringup: RTL and testbench

AXI4-Lite master that brings up a JESD204 TX link through the TX core register map. On `start` it runs a fixed write sequence: hold link disabled, program lane/link/common/TX configuration, then release the link. It then polls the status register until the link reports DATA with all SYNC deasserted. It sits between a system supervisor (or boot FSM) and the TX core's `s_axi` slave port, replacing software bring-up in processor-less designs.

---
 rtl/jesd204_tx_link_bringup.sv | 277 +++++++++++++++++++++++++++
 tb/tb_jesd204_tx_link_bringup.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/jesd204_tx_link_bringup.sv
// ----------------------------------------------------------------------------
// jesd204_tx_link_bringup
//
// Purpose: AXI4-Lite master that brings up a JESD204 TX link through the TX
// core register map, for designs without a processor. A start pulse samples
// the cfg_* inputs and then runs a fixed write sequence:
//   0x0C0=1 (hold link disabled), 0x200 lanes_disable, 0x210 common0,
//   0x214 common1, 0x218 links_disable, 0x240 tx_conf, 0x0C0=0 (release).
// After the writes it polls status register 0x280 every POLL_INTERVAL cycles.
// The link is up when state bits [1:0]==2'b11 and every SYNC bit
// rdata[4 +: NUM_LINKS] reads 1.
//
// Optional feature: macro JESD204_TX_BRINGUP_MONITOR_EN. When defined, the
// block keeps polling after the link is up, with busy low, and reports a
// lost link as error code 4. When undefined, the linked state is terminal.
//
// Ports:
//   clk, reset            clock and asynchronous active-high reset
//   start                 one-cycle pulse; ignored while busy
//   cfg_*                 register values, sampled on an accepted start
//   busy / linked / error sequence running / link up / sticky error flag
//   error_code            0 none, 1 BRESP, 2 RRESP, 3 timeout, 4 link lost
//   link_state            bits [1:0] of the last good status read
//   m_axi_*               AXI4-Lite master (14-bit address, 32-bit data)
// ----------------------------------------------------------------------------
module jesd204_tx_link_bringup #(
  parameter int NUM_LANES     = 2,
  parameter int NUM_LINKS     = 2,
  parameter int POLL_INTERVAL = 256,
  parameter int TIMEOUT_POLLS = 1024
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [NUM_LANES-1:0] cfg_lanes_disable,
  input  logic [31:0]          cfg_common0,
  input  logic [31:0]          cfg_common1,
  input  logic [NUM_LINKS-1:0] cfg_links_disable,
  input  logic [31:0]          cfg_tx_conf,
  output logic                 busy,
  output logic                 linked,
  output logic                 error,
  output logic [2:0]           error_code,
  output logic [1:0]           link_state,
  output logic                 m_axi_awvalid,
  input  logic                 m_axi_awready,
  output logic [13:0]          m_axi_awaddr,
  output logic [2:0]           m_axi_awprot,
  output logic                 m_axi_wvalid,
  input  logic                 m_axi_wready,
  output logic [31:0]          m_axi_wdata,
  output logic [3:0]           m_axi_wstrb,
  input  logic                 m_axi_bvalid,
  output logic                 m_axi_bready,
  input  logic [1:0]           m_axi_bresp,
  output logic                 m_axi_arvalid,
  input  logic                 m_axi_arready,
  output logic [13:0]          m_axi_araddr,
  output logic [2:0]           m_axi_arprot,
  input  logic                 m_axi_rvalid,
  output logic                 m_axi_rready,
  input  logic [31:0]          m_axi_rdata,
  input  logic [1:0]           m_axi_rresp
);

  localparam logic [13:0] STATUS_ADDR  = 14'h280;
  localparam logic [15:0] WAIT_LAST    = 16'(POLL_INTERVAL - 1);
  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_POLLS);

  typedef enum logic [2:0] {
    S_IDLE, S_WR_REQ, S_WR_RESP, S_POLL_WAIT, S_RD_REQ, S_RD_RESP, S_LINKED, S_ERROR
  } state_t;

  state_t              state_q;
  logic [NUM_LANES-1:0] lanes_q;
  logic [NUM_LINKS-1:0] links_q;
  logic [31:0]         common0_q, common1_q, tx_conf_q;
  logic [2:0]          wr_idx_q, wr_idx_d;
  logic [13:0]         wr_addr_d, awaddr_q, araddr_q;
  logic [31:0]         wr_data_d, wdata_q;
  logic [15:0]         wait_cnt_q, poll_cnt_q, poll_cnt_d;
  logic                awvalid_q, wvalid_q, bready_q, arvalid_q, rready_q;
  logic                busy_q, linked_q, error_q, mon_q;
  logic [2:0]          error_code_q;
  logic [1:0]          link_state_q;
  logic                start_ok, status_ok;
  logic                unused_rdata;

  // Index and payload of the write to launch next: the first write after a
  // start, or the one following the write whose response is being taken.
  always_comb begin
    wr_idx_d  = (state_q == S_WR_RESP) ? wr_idx_q + 3'd1 : 3'd0;
    wr_addr_d = 14'h0C0;
    wr_data_d = 32'd0;
    case (wr_idx_d)
      3'd0: begin wr_addr_d = 14'h0C0; wr_data_d = 32'd1;             end
      3'd1: begin wr_addr_d = 14'h200; wr_data_d = 32'(lanes_q);      end
      3'd2: begin wr_addr_d = 14'h210; wr_data_d = common0_q;         end
      3'd3: begin wr_addr_d = 14'h214; wr_data_d = common1_q;         end
      3'd4: begin wr_addr_d = 14'h218; wr_data_d = 32'(links_q);      end
      3'd5: begin wr_addr_d = 14'h240; wr_data_d = tx_conf_q;         end
      default: begin wr_addr_d = 14'h0C0; wr_data_d = 32'd0;          end
    endcase
  end

  // A start is taken only when no AXI transaction is in flight, so a restart
  // can never withdraw a valid before its ready. While monitoring, a start
  // that lands in the middle of a status read is ignored like any busy start.
  always_comb begin
    start_ok = 1'b0;
    case (state_q)
      S_IDLE, S_LINKED, S_ERROR: start_ok = 1'b1;
      S_POLL_WAIT:               start_ok = mon_q;
      default:                   start_ok = 1'b0;
    endcase
  end

  assign poll_cnt_d   = poll_cnt_q + 16'd1;
  assign status_ok    = (m_axi_rdata[1:0] == 2'b11) && (&m_axi_rdata[4 +: NUM_LINKS]);
  assign unused_rdata = ^{m_axi_rdata[31:4+NUM_LINKS], m_axi_rdata[3:2]};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      lanes_q      <= '0;
      links_q      <= '0;
      common0_q    <= '0;
      common1_q    <= '0;
      tx_conf_q    <= '0;
      wr_idx_q     <= '0;
      awaddr_q     <= '0;
      araddr_q     <= '0;
      wdata_q      <= '0;
      wait_cnt_q   <= '0;
      poll_cnt_q   <= '0;
      awvalid_q    <= 1'b0;
      wvalid_q     <= 1'b0;
      bready_q     <= 1'b0;
      arvalid_q    <= 1'b0;
      rready_q     <= 1'b0;
      busy_q       <= 1'b0;
      linked_q     <= 1'b0;
      error_q      <= 1'b0;
      mon_q        <= 1'b0;
      error_code_q <= 3'd0;
      link_state_q <= 2'd0;
    end else if (start && start_ok) begin
      lanes_q      <= cfg_lanes_disable;
      links_q      <= cfg_links_disable;
      common0_q    <= cfg_common0;
      common1_q    <= cfg_common1;
      tx_conf_q    <= cfg_tx_conf;
      error_q      <= 1'b0;
      error_code_q <= 3'd0;
      linked_q     <= 1'b0;
      mon_q        <= 1'b0;
      busy_q       <= 1'b1;
      wr_idx_q     <= 3'd0;
      poll_cnt_q   <= '0;
      wait_cnt_q   <= '0;
      awaddr_q     <= wr_addr_d;
      wdata_q      <= wr_data_d;
      awvalid_q    <= 1'b1;
      wvalid_q     <= 1'b1;
      state_q      <= S_WR_REQ;
    end else begin
      case (state_q)
        S_WR_REQ: begin
          // Address and data channels complete independently, in any order.
          if (awvalid_q && m_axi_awready) awvalid_q <= 1'b0;
          if (wvalid_q && m_axi_wready)   wvalid_q  <= 1'b0;
          if ((!awvalid_q || m_axi_awready) && (!wvalid_q || m_axi_wready)) begin
            bready_q <= 1'b1;
            state_q  <= S_WR_RESP;
          end
        end
        S_WR_RESP: begin
          if (m_axi_bvalid) begin
            bready_q <= 1'b0;
            if (m_axi_bresp != 2'b00) begin
              busy_q       <= 1'b0;
              error_q      <= 1'b1;
              error_code_q <= 3'd1;
              state_q      <= S_ERROR;
            end else if (wr_idx_q == 3'd6) begin
              wait_cnt_q <= '0;
              state_q    <= S_POLL_WAIT;
            end else begin
              wr_idx_q  <= wr_idx_d;
              awaddr_q  <= wr_addr_d;
              wdata_q   <= wr_data_d;
              awvalid_q <= 1'b1;
              wvalid_q  <= 1'b1;
              state_q   <= S_WR_REQ;
            end
          end
        end
        S_POLL_WAIT: begin
          if (wait_cnt_q == WAIT_LAST) begin
            wait_cnt_q <= '0;
            araddr_q   <= STATUS_ADDR;
            arvalid_q  <= 1'b1;
            state_q    <= S_RD_REQ;
          end else begin
            wait_cnt_q <= wait_cnt_q + 16'd1;
          end
        end
        S_RD_REQ: begin
          if (m_axi_arready) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            state_q   <= S_RD_RESP;
          end
        end
        S_RD_RESP: begin
          if (m_axi_rvalid) begin
            rready_q <= 1'b0;
            if (m_axi_rresp != 2'b00) begin
              busy_q       <= 1'b0;
              linked_q     <= 1'b0;
              error_q      <= 1'b1;
              error_code_q <= 3'd2;
              state_q      <= S_ERROR;
            end else begin
              link_state_q <= m_axi_rdata[1:0];
              if (status_ok) begin
                linked_q <= 1'b1;
                busy_q   <= 1'b0;
`ifdef JESD204_TX_BRINGUP_MONITOR_EN
                // Keep watching the link; mon_q keeps busy low and turns a
                // bad status into "link lost" instead of another retry.
                mon_q      <= 1'b1;
                wait_cnt_q <= '0;
                state_q    <= S_POLL_WAIT;
`else
                state_q  <= S_LINKED;
`endif
              end else if (mon_q) begin
                linked_q     <= 1'b0;
                error_q      <= 1'b1;
                error_code_q <= 3'd4;
                state_q      <= S_ERROR;
              end else if (poll_cnt_d == TIMEOUT_LAST) begin
                busy_q       <= 1'b0;
                error_q      <= 1'b1;
                error_code_q <= 3'd3;
                state_q      <= S_ERROR;
              end else begin
                poll_cnt_q <= poll_cnt_d;
                state_q    <= S_POLL_WAIT;
              end
            end
          end
        end
        default: ;  // S_IDLE, S_LINKED, S_ERROR wait for start
      endcase
    end
  end

  assign busy          = busy_q;
  assign linked        = linked_q;
  assign error         = error_q;
  assign error_code    = error_code_q;
  assign link_state    = link_state_q;
  assign m_axi_awvalid = awvalid_q;
  assign m_axi_awaddr  = awaddr_q;
  assign m_axi_awprot  = 3'b000;
  assign m_axi_wvalid  = wvalid_q;
  assign m_axi_wdata   = wdata_q;
  assign m_axi_wstrb   = 4'hF;
  assign m_axi_bready  = bready_q;
  assign m_axi_arvalid = arvalid_q;
  assign m_axi_araddr  = araddr_q;
  assign m_axi_arprot  = 3'b000;
  assign m_axi_rready  = rready_q;

endmodule

// File: tb/tb_jesd204_tx_link_bringup.sv
`timescale 1ns/1ps
module tb_jesd204_tx_link_bringup;
  localparam int NL = 2, NK = 2, PI = 4, TP = 3;

  logic clk = 1'b0, reset = 1'b1, start = 1'b0;
  always #5 clk = ~clk;

  logic [NL-1:0] cfg_lanes = '0;
  logic [NK-1:0] cfg_links = '0;
  logic [31:0]   cfg_c0 = '0, cfg_c1 = '0, cfg_tx = '0;
  logic          busy, linked, error;
  logic [2:0]    error_code;
  logic [1:0]    link_state;
  logic          m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready;
  logic [13:0]   m_axi_awaddr, m_axi_araddr;
  logic [2:0]    m_axi_awprot, m_axi_arprot;
  logic [31:0]   m_axi_wdata;
  logic [3:0]    m_axi_wstrb;
  logic          awready = 0, wready = 0, bvalid = 0, arready = 0, rvalid = 0;
  logic [1:0]    bresp = 0, rresp = 0;
  logic [31:0]   rdata = 0;

  jesd204_tx_link_bringup #(.NUM_LANES(NL), .NUM_LINKS(NK), .POLL_INTERVAL(PI), .TIMEOUT_POLLS(TP)) dut (
    .clk(clk), .reset(reset), .start(start),
    .cfg_lanes_disable(cfg_lanes), .cfg_common0(cfg_c0), .cfg_common1(cfg_c1),
    .cfg_links_disable(cfg_links), .cfg_tx_conf(cfg_tx),
    .busy(busy), .linked(linked), .error(error), .error_code(error_code), .link_state(link_state),
    .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(awready), .m_axi_awaddr(m_axi_awaddr), .m_axi_awprot(m_axi_awprot),
    .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(wready), .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb),
    .m_axi_bvalid(bvalid), .m_axi_bready(m_axi_bready), .m_axi_bresp(bresp),
    .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(arready), .m_axi_araddr(m_axi_araddr), .m_axi_arprot(m_axi_arprot),
    .m_axi_rvalid(rvalid), .m_axi_rready(m_axi_rready), .m_axi_rdata(rdata), .m_axi_rresp(rresp)
  );

  typedef struct packed { logic [13:0] addr; logic [31:0] data; } wr_t;
  wr_t sb[$];                       // expected writes, in order

  int checks = 0, errors = 0;
  int wr_count = 0, rd_count = 0, rd_done = 0;
  int wr_base = 0, rd_base = 0, rd_done_base = 0;
  int aw_dly[7], w_dly[7];
  int bresp_err_idx = -1;
  logic [31:0] status_arr[4];
  int n_status = 0;
  logic [31:0] status_default = 32'h33;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Handshakes as seen on the active edge (DUT outputs still pre-edge here).
  logic aw_hs = 0, w_hs = 0, b_hs = 0, ar_hs = 0, r_hs = 0;
  logic aw_pend = 0, w_pend = 0, ar_pend = 0;
  logic [13:0] aw_addr_cap = 0, ar_addr_cap = 0;
  logic [31:0] w_data_cap = 0;
  logic [3:0]  wstrb_cap = 0;
  always @(posedge clk) begin
    aw_hs = m_axi_awvalid && awready;  aw_pend = m_axi_awvalid && !awready;
    w_hs  = m_axi_wvalid && wready;    w_pend  = m_axi_wvalid && !wready;
    ar_hs = m_axi_arvalid && arready;  ar_pend = m_axi_arvalid && !arready;
    b_hs  = bvalid && m_axi_bready;
    r_hs  = rvalid && m_axi_rready;
    aw_addr_cap = m_axi_awaddr; ar_addr_cap = m_axi_araddr;
    w_data_cap  = m_axi_wdata;  wstrb_cap   = m_axi_wstrb;
  end

  // AXI4-Lite slave model with per-write ready delays; drives on negedge.
  logic got_aw = 0, got_w = 0;
  logic [13:0] got_addr = 0;
  logic [31:0] got_data = 0;
  logic [3:0]  got_strb = 0;
  int aw_wait = 0, w_wait = 0, wi = 0, ri = 0;
  wr_t exp_wr;
  always @(negedge clk) begin
    if (reset) begin
      awready = 0; wready = 0; bvalid = 0; arready = 0; rvalid = 0;
      got_aw = 0; got_w = 0; aw_wait = 0; w_wait = 0;
    end else begin
      if (aw_pend) chk("awvalid_held", 32'(m_axi_awvalid), 32'd1);
      if (w_pend)  chk("wvalid_held", 32'(m_axi_wvalid), 32'd1);
      if (ar_pend) chk("arvalid_held", 32'(m_axi_arvalid), 32'd1);
      if (b_hs) bvalid = 0;
      if (aw_hs) begin got_aw = 1; got_addr = aw_addr_cap; awready = 0; aw_wait = 0; end
      if (w_hs)  begin got_w = 1; got_data = w_data_cap; got_strb = wstrb_cap; wready = 0; w_wait = 0; end
      if (got_aw && got_w) begin
        got_aw = 0; got_w = 0;
        chk("write_expected", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
          exp_wr = sb.pop_front();
          chk("wr_addr", 32'(got_addr), 32'(exp_wr.addr));
          chk("wr_data", got_data, exp_wr.data);
          chk("wr_strb", 32'(got_strb), 32'hF);
        end
        $display("write #%0d addr=0x%03h data=0x%08h", wr_count - wr_base, got_addr, got_data);
        bresp = ((wr_count - wr_base) == bresp_err_idx) ? 2'b10 : 2'b00;
        bvalid = 1;
        wr_count++;
      end
      wi = wr_count - wr_base;
      if (wi > 6) wi = 6;
      if (m_axi_awvalid && !awready && !got_aw) begin
        if (aw_wait >= aw_dly[wi]) awready = 1; else aw_wait++;
      end
      if (m_axi_wvalid && !wready && !got_w) begin
        if (w_wait >= w_dly[wi]) wready = 1; else w_wait++;
      end
      if (r_hs) begin rvalid = 0; rd_done++; end
      if (ar_hs) begin
        arready = 0;
        ri = rd_count - rd_base;
        rdata = (ri < n_status) ? status_arr[ri] : status_default;
        rresp = 2'b00;
        rvalid = 1;
        chk("rd_addr", 32'(ar_addr_cap), 32'h280);
        $display("read  #%0d addr=0x%03h data=0x%08h", ri, ar_addr_cap, rdata);
        rd_count++;
      end
      if (m_axi_arvalid && !arready && !ar_hs) arready = 1;
    end
  end

  task automatic tick();
    @(negedge clk); #1;
  endtask

  task automatic push_seq(input int n);
    wr_t full[7];
    full[0] = '{addr: 14'h0C0, data: 32'd1};
    full[1] = '{addr: 14'h200, data: 32'(cfg_lanes)};
    full[2] = '{addr: 14'h210, data: cfg_c0};
    full[3] = '{addr: 14'h214, data: cfg_c1};
    full[4] = '{addr: 14'h218, data: 32'(cfg_links)};
    full[5] = '{addr: 14'h240, data: cfg_tx};
    full[6] = '{addr: 14'h0C0, data: 32'd0};
    for (int i = 0; i < n; i++) sb.push_back(full[i]);
  endtask

  task automatic do_start(input int n_expect);
    for (int i = 0; i < 50 && (m_axi_arvalid || m_axi_rready); i++) tick();
    wr_base = wr_count; rd_base = rd_count; rd_done_base = rd_done;
    push_seq(n_expect);
    start = 1; tick(); start = 0;
    // Inputs changed after start must not reach the bus.
    cfg_lanes = ~cfg_lanes; cfg_c0 = ~cfg_c0; cfg_c1 = ~cfg_c1;
    cfg_links = ~cfg_links; cfg_tx = ~cfg_tx;
    chk("busy_after_start", 32'(busy), 32'd1);
    chk("error_cleared", 32'(error), 32'd0);
    chk("linked_cleared", 32'(linked), 32'd0);
  endtask

  task automatic wait_done(input string tag, input int max);
    int n = 0;
    while (!(linked || error) && n < max) begin tick(); n++; end
    chk({tag, "_finished"}, 32'(linked || error), 32'd1);
  endtask

  task automatic wait_reads(input int k, input int max);
    int n = 0;
    while ((rd_done - rd_done_base) < k && n < max) begin tick(); n++; end
    chk("read_arrived", 32'((rd_done - rd_done_base) >= k), 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed=no finish expected=finish");
    $fatal(1, "watchdog expired");
  end

  int wr_snap, rd_snap;
  logic [31:0] s;

  initial begin
    for (int i = 0; i < 7; i++) begin aw_dly[i] = 0; w_dly[i] = 0; end
    for (int i = 0; i < 4; i++) status_arr[i] = 32'h33;

    // Reset state
    tick(); tick();
    chk("rst_busy", 32'(busy), 0);           chk("rst_linked", 32'(linked), 0);
    chk("rst_error", 32'(error), 0);         chk("rst_code", 32'(error_code), 0);
    chk("rst_state", 32'(link_state), 0);    chk("rst_awvalid", 32'(m_axi_awvalid), 0);
    chk("rst_wvalid", 32'(m_axi_wvalid), 0); chk("rst_arvalid", 32'(m_axi_arvalid), 0);
    chk("rst_bready", 32'(m_axi_bready), 0); chk("rst_rready", 32'(m_axi_rready), 0);
    chk("rst_awaddr", 32'(m_axi_awaddr), 0); chk("rst_wdata", m_axi_wdata, 0);
    reset = 0; tick();

    // T1: zero-wait slave, link up on first status read
    cfg_lanes = 2'b10; cfg_c0 = 32'hA5A5_0001; cfg_c1 = 32'h0000_1234;
    cfg_links = 2'b01; cfg_tx = 32'hDEAD_BEEF;
    status_arr[0] = 32'h33; n_status = 1; status_default = 32'h33;
    do_start(7);
    wait_done("t1", 300);
    chk("t1_linked", 32'(linked), 1);   chk("t1_busy", 32'(busy), 0);
    chk("t1_code", 32'(error_code), 0); chk("t1_error", 32'(error), 0);
    chk("t1_writes", wr_count - wr_base, 7); chk("t1_reads", rd_count - rd_base, 1);
    chk("t1_sb_empty", sb.size(), 0);   chk("t1_link_state", 32'(link_state), 3);

    // T2: staggered ready timing, ignored restart, link state stepping 1,2,3
    aw_dly[1] = 2; w_dly[1] = 0;   // data accepted before address
    aw_dly[2] = 0; w_dly[2] = 3;   // address 3 cycles before data
    aw_dly[3] = 0; w_dly[3] = 0;   // together
    cfg_lanes = 2'b01; cfg_c0 = 32'h1357_9BDF; cfg_c1 = 32'h8000_0042;
    cfg_links = 2'b10; cfg_tx = 32'h0F0F_00FF;
    status_arr[0] = 32'h01; status_arr[1] = 32'h02; status_arr[2] = 32'h33; n_status = 3;
    do_start(7);
    tick(); tick(); tick();
    start = 1; tick(); start = 0;   // busy: must be ignored
    for (int k = 0; k < 3; k++) begin
      wait_reads(k + 1, 300);
      s = status_arr[k];
      chk("t2_link_state", 32'(link_state), 32'(s[1:0]));
    end
    wait_done("t2", 50);
    chk("t2_linked", 32'(linked), 1);   chk("t2_writes", wr_count - wr_base, 7);
    chk("t2_reads", rd_count - rd_base, 3); chk("t2_sb_empty", sb.size(), 0);
    for (int i = 0; i < 7; i++) begin aw_dly[i] = 0; w_dly[i] = 0; end

    // T3: SYNC never deasserts -> timeout after TP reads, then silence
    n_status = 0; status_default = 32'h03;
    do_start(7);
    wait_done("t3", 400);
    chk("t3_error", 32'(error), 1);     chk("t3_code", 32'(error_code), 3);
    chk("t3_linked", 32'(linked), 0);   chk("t3_busy", 32'(busy), 0);
    chk("t3_reads", rd_count - rd_base, TP); chk("t3_link_state", 32'(link_state), 3);
    wr_snap = wr_count; rd_snap = rd_count;
    repeat (30) tick();
    chk("t3_quiet_wr", wr_count, wr_snap); chk("t3_quiet_rd", rd_count, rd_snap);
    chk("t3_quiet_ar", 32'(m_axi_arvalid), 0);

    // T4: BRESP error on write 5, then a clean restart
    status_default = 32'h33; bresp_err_idx = 4;
    do_start(5);
    wait_done("t4", 300);
    chk("t4_error", 32'(error), 1); chk("t4_code", 32'(error_code), 1);
    chk("t4_writes", wr_count - wr_base, 5); chk("t4_sb_empty", sb.size(), 0);
    wr_snap = wr_count;
    repeat (20) tick();
    chk("t4_no_more_writes", wr_count, wr_snap);
    bresp_err_idx = -1;
    do_start(7);
    wait_done("t4r", 300);
    chk("t4r_linked", 32'(linked), 1); chk("t4r_code", 32'(error_code), 0);
    chk("t4r_writes", wr_count - wr_base, 7); chk("t4r_sb_empty", sb.size(), 0);

`ifdef JESD204_TX_BRINGUP_MONITOR_EN
    // Monitoring: link stays up while status is good, then loss is reported
    repeat (3 * (PI + 6)) tick();
    chk("mon_linked", 32'(linked), 1); chk("mon_busy", 32'(busy), 0);
    chk("mon_reads_continue", 32'((rd_count - rd_base) > 1), 1);
    status_default = 32'h13;
    for (int n = 0; n < PI + 12 && !error; n++) tick();
    chk("mon_error", 32'(error), 1); chk("mon_code", 32'(error_code), 4);
    chk("mon_linked_drop", 32'(linked), 0);
    status_default = 32'h33;
`endif

    // Reset in the middle of a write request
    do_start(7);
    for (int n = 0; n < 20 && !m_axi_awvalid; n++) tick();
    chk("mid_awvalid_seen", 32'(m_axi_awvalid), 1);
    reset = 1; #1;
    chk("ar_awvalid", 32'(m_axi_awvalid), 0); chk("ar_wvalid", 32'(m_axi_wvalid), 0);
    chk("ar_bready", 32'(m_axi_bready), 0);   chk("ar_busy", 32'(busy), 0);
    chk("ar_awaddr", 32'(m_axi_awaddr), 0);
    sb.delete();
    tick(); tick();
    reset = 0;
    wr_snap = wr_count;
    repeat (10) tick();
    chk("ar_idle_busy", 32'(busy), 0); chk("ar_idle_awvalid", 32'(m_axi_awvalid), 0);
    chk("ar_idle_writes", wr_count, wr_snap);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
